// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
package pipe_pkg;

  // Stage-register control state: normal flow, or holding for the multi-cycle FPU.
  typedef enum logic {
    RUN      = 1'b0,
    FPU_WAIT = 1'b1
  } stage_state_t;

  // Default widths shared by all stage registers.
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_W  = 5;

endpackage

// File: rtl/fpu_wait_ctrl.sv
// FPU interlock control: RUN/FPU_WAIT state machine, timeout counter and sticky timeout error.
module fpu_wait_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FPU_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic         i_done,
  input  logic         i_stall,
  input  logic         i_flush,
  output stage_state_t o_state,
  output logic         o_capture_en,
  output logic         o_take_fpu_result,
  output logic         o_timeout_abort,
  output logic         o_timeout_err
);

  localparam int unsigned CNT_W = (FPU_TIMEOUT > 1) ? $clog2(FPU_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FPU_TIMEOUT - 1);

  stage_state_t     r_state;
  stage_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_timeout_err;

  // State, counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_timeout_err <= r_timeout_err | o_timeout_abort;
    end
  end

  // Next-state and stage-control decode; stall/flush only matter in RUN.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    o_capture_en      = 1'b0;
    o_take_fpu_result = 1'b0;
    o_timeout_abort   = 1'b0;
    case (r_state)
      RUN: begin
        if (!i_flush && !i_stall) begin
          o_capture_en = 1'b1;
          if (i_start) begin
            w_state_nxt = FPU_WAIT;
            w_cnt_nxt   = '0;
          end
        end
      end
      FPU_WAIT: begin
        if (i_done) begin
          o_take_fpu_result = 1'b1;
          w_state_nxt       = RUN;
        end else if (r_cnt == LAST_CNT) begin
          o_timeout_abort = 1'b1;
          w_state_nxt     = RUN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign o_state       = r_state;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: rtl/exmem_stage_reg.sv
// EX->MEM pipeline stage register with valid bit, stall/flush and FPU interlock.
module exmem_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned REG_W       = DEF_REG_W,
  parameter int unsigned CTRL_W      = 8,
  parameter int unsigned FPU_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              e_valid,
  input  logic [DATA_W-1:0] e_alu_result,
  input  logic [DATA_W-1:0] e_write_data,
  input  logic [REG_W-1:0]  e_rd,
  input  logic [DATA_W-1:0] e_pc_plus4,
  input  logic [CTRL_W-1:0] e_ctrl,
  input  logic              e_fpu_start,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              fpu_done_i,
  input  logic [DATA_W-1:0] fpu_result_i,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_alu_result,
  output logic [DATA_W-1:0] m_write_data,
  output logic [REG_W-1:0]  m_rd,
  output logic [DATA_W-1:0] m_pc_plus4,
  output logic [CTRL_W-1:0] m_ctrl,
  output logic              m_fpu_start,
  output logic              m_commit,
  output logic              stall_upstream_o,
  output logic              fpu_timeout_o
);

  stage_state_t      w_state;
  logic              w_start;
  logic              w_capture_en;
  logic              w_take_fpu_result;
  logic              w_timeout_abort;
  logic              w_timeout_err;

  logic              r_valid;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_write_data;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_pc_plus4;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_fpu_start;

  assign w_start = e_valid & e_fpu_start;

  fpu_wait_ctrl #(
    .FPU_TIMEOUT (FPU_TIMEOUT)
  ) u_ctrl (
    .clk               (clk),
    .reset             (reset),
    .i_start           (w_start),
    .i_done            (fpu_done_i),
    .i_stall           (stall_i),
    .i_flush           (flush_i),
    .o_state           (w_state),
    .o_capture_en      (w_capture_en),
    .o_take_fpu_result (w_take_fpu_result),
    .o_timeout_abort   (w_timeout_abort),
    .o_timeout_err     (w_timeout_err)
  );

  // Stage data flops: capture, flush bubble, FPU result write-back and timeout drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_rd         <= '0;
      r_pc_plus4   <= '0;
      r_ctrl       <= '0;
      r_fpu_start  <= 1'b0;
    end else begin
      // Start pulse only on a fresh capture, so a stall never repeats it.
      r_fpu_start <= w_capture_en & w_start;
      if (w_capture_en) begin
        r_valid      <= e_valid;
        r_alu_result <= e_alu_result;
        r_write_data <= e_write_data;
        r_rd         <= e_rd;
        r_pc_plus4   <= e_pc_plus4;
        r_ctrl       <= e_ctrl;
      end else if (w_state == RUN && flush_i) begin
        r_valid <= 1'b0;
      end
      if (w_take_fpu_result) begin
        r_alu_result <= fpu_result_i;
      end
      if (w_timeout_abort) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_valid          = r_valid;
  assign m_alu_result     = r_alu_result;
  assign m_write_data     = r_write_data;
  assign m_rd             = r_rd;
  assign m_pc_plus4       = r_pc_plus4;
  assign m_ctrl           = r_ctrl;
  assign m_fpu_start      = r_fpu_start;
  assign m_commit         = r_valid && (w_state == RUN);
  assign stall_upstream_o = (w_state == FPU_WAIT);
  assign fpu_timeout_o    = w_timeout_err;

endmodule

// File: tb/tb_exmem_stage_reg.sv
// Directed self-checking bench for exmem_stage_reg with FPU_TIMEOUT=8.
module tb_exmem_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned TMO    = 8;

  logic              clk;
  logic              reset;
  logic              e_valid;
  logic [DATA_W-1:0] e_alu_result;
  logic [DATA_W-1:0] e_write_data;
  logic [REG_W-1:0]  e_rd;
  logic [DATA_W-1:0] e_pc_plus4;
  logic [CTRL_W-1:0] e_ctrl;
  logic              e_fpu_start;
  logic              stall_i;
  logic              flush_i;
  logic              fpu_done_i;
  logic [DATA_W-1:0] fpu_result_i;
  logic              m_valid;
  logic [DATA_W-1:0] m_alu_result;
  logic [DATA_W-1:0] m_write_data;
  logic [REG_W-1:0]  m_rd;
  logic [DATA_W-1:0] m_pc_plus4;
  logic [CTRL_W-1:0] m_ctrl;
  logic              m_fpu_start;
  logic              m_commit;
  logic              stall_upstream_o;
  logic              fpu_timeout_o;

  int unsigned n_total;
  int unsigned n_bad;

  exmem_stage_reg #(
    .DATA_W      (DATA_W),
    .REG_W       (REG_W),
    .CTRL_W      (CTRL_W),
    .FPU_TIMEOUT (TMO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .e_valid          (e_valid),
    .e_alu_result     (e_alu_result),
    .e_write_data     (e_write_data),
    .e_rd             (e_rd),
    .e_pc_plus4       (e_pc_plus4),
    .e_ctrl           (e_ctrl),
    .e_fpu_start      (e_fpu_start),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .fpu_done_i       (fpu_done_i),
    .fpu_result_i     (fpu_result_i),
    .m_valid          (m_valid),
    .m_alu_result     (m_alu_result),
    .m_write_data     (m_write_data),
    .m_rd             (m_rd),
    .m_pc_plus4       (m_pc_plus4),
    .m_ctrl           (m_ctrl),
    .m_fpu_start      (m_fpu_start),
    .m_commit         (m_commit),
    .stall_upstream_o (stall_upstream_o),
    .fpu_timeout_o    (fpu_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_e(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                         input logic fpu);
    e_valid      = v;
    e_alu_result = alu;
    e_write_data = alu ^ 32'hFFFF_0000;
    e_rd         = rd;
    e_pc_plus4   = alu + 32'd4;
    e_ctrl       = alu[7:0];
    e_fpu_start  = fpu;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"},  64'(m_valid),          64'd0);
    check({tag, ".alu"},    64'(m_alu_result),     64'd0);
    check({tag, ".wd"},     64'(m_write_data),     64'd0);
    check({tag, ".rd"},     64'(m_rd),             64'd0);
    check({tag, ".pc4"},    64'(m_pc_plus4),       64'd0);
    check({tag, ".ctrl"},   64'(m_ctrl),           64'd0);
    check({tag, ".fstart"}, 64'(m_fpu_start),      64'd0);
    check({tag, ".commit"}, 64'(m_commit),         64'd0);
    check({tag, ".stall"},  64'(stall_upstream_o), 64'd0);
    check({tag, ".tmo"},    64'(fpu_timeout_o),    64'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0; fpu_done_i = 1'b0; fpu_result_i = '0;
    drive_e(1'b0, 32'h0, 5'd0, 1'b0);
    tick(); tick();
    check_zero("reset");

    // Plain flow.
    reset = 1'b0;
    drive_e(1'b1, 32'h0000_1234, 5'd5, 1'b0);
    tick();
    check("flow.alu",    64'(m_alu_result), 64'h1234);
    check("flow.rd",     64'(m_rd),         64'd5);
    check("flow.wd",     64'(m_write_data), 64'hFFFF_1234);
    check("flow.pc4",    64'(m_pc_plus4),   64'h1238);
    check("flow.ctrl",   64'(m_ctrl),       64'h34);
    check("flow.commit", 64'(m_commit),     64'd1);
    check("flow.fstart", 64'(m_fpu_start),  64'd0);
    check("flow.stall",  64'(stall_upstream_o), 64'd0);

    // Stall holds contents while E changes.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_e(1'b1, 32'hA000_0000 + 32'(i), 5'(10 + i), 1'b1);
      tick();
      check("stall.alu",   64'(m_alu_result), 64'h1234);
      check("stall.rd",    64'(m_rd),         64'd5);
      check("stall.valid", 64'(m_valid),      64'd1);
      check("stall.fstart", 64'(m_fpu_start), 64'd0);
    end
    // Flush wins over stall.
    flush_i = 1'b1;
    tick();
    check("flush.valid",  64'(m_valid),  64'd0);
    check("flush.commit", 64'(m_commit), 64'd0);
    flush_i = 1'b0; stall_i = 1'b0;

    // Another capture pattern, then a bubble.
    drive_e(1'b1, 32'hDEAD_BEEF, 5'd31, 1'b0);
    tick();
    check("cap2.alu", 64'(m_alu_result), 64'hDEAD_BEEF);
    check("cap2.rd",  64'(m_rd),         64'd31);
    check("cap2.pc4", 64'(m_pc_plus4),   64'hDEAD_BEF3);
    drive_e(1'b0, 32'h0000_0042, 5'd1, 1'b1);
    tick();
    check("bubble.valid",  64'(m_valid),          64'd0);
    check("bubble.fstart", 64'(m_fpu_start),      64'd0);
    check("bubble.stall",  64'(stall_upstream_o), 64'd0);

    // fpu_done in RUN is ignored.
    drive_e(1'b1, 32'h0000_0055, 5'd3, 1'b0);
    tick();
    stall_i = 1'b1; fpu_done_i = 1'b1; fpu_result_i = 32'h0000_FFFF;
    tick();
    check("rundone.alu",   64'(m_alu_result),     64'h55);
    check("rundone.stall", 64'(stall_upstream_o), 64'd0);
    stall_i = 1'b0; fpu_done_i = 1'b0;

    // FPU happy path, done sampled at edge N+4.
    drive_e(1'b1, 32'h0000_0100, 5'd7, 1'b1);
    tick();
    check("fpu.fstart0", 64'(m_fpu_start),      64'd1);
    check("fpu.stall0",  64'(stall_upstream_o), 64'd1);
    check("fpu.commit0", 64'(m_commit),         64'd0);
    check("fpu.valid0",  64'(m_valid),          64'd1);
    drive_e(1'b1, 32'h0000_0777, 5'd9, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("fpu.fstartw", 64'(m_fpu_start),      64'd0);
      check("fpu.stallw",  64'(stall_upstream_o), 64'd1);
      check("fpu.aluw",    64'(m_alu_result),     64'h100);
    end
    fpu_done_i = 1'b1; fpu_result_i = 32'h3F80_0000;
    tick();
    fpu_done_i = 1'b0;
    check("fpu.result", 64'(m_alu_result),     64'h3F80_0000);
    check("fpu.commit", 64'(m_commit),         64'd1);
    check("fpu.stall",  64'(stall_upstream_o), 64'd0);
    check("fpu.rd",     64'(m_rd),             64'd7);
    tick();
    check("fpu.next.alu", 64'(m_alu_result), 64'h777);
    check("fpu.next.rd",  64'(m_rd),         64'd9);

    // Minimum latency: done right after the start pulse.
    drive_e(1'b1, 32'h0000_0200, 5'd4, 1'b1);
    tick();
    drive_e(1'b0, 32'h0, 5'd0, 1'b0);
    fpu_done_i = 1'b1; fpu_result_i = 32'h4000_0000;
    tick();
    fpu_done_i = 1'b0;
    check("k1.result", 64'(m_alu_result), 64'h4000_0000);
    check("k1.commit", 64'(m_commit),     64'd1);
    check("k1.fstart", 64'(m_fpu_start),  64'd0);

    // Done on the terminal timeout cycle beats the timeout.
    drive_e(1'b1, 32'h0000_0300, 5'd6, 1'b1);
    tick();
    drive_e(1'b0, 32'h0, 5'd0, 1'b0);
    for (int i = 1; i < int'(TMO); i++) tick();
    check("term.stall", 64'(stall_upstream_o), 64'd1);
    fpu_done_i = 1'b1; fpu_result_i = 32'h1111_2222;
    tick();
    fpu_done_i = 1'b0;
    check("term.result", 64'(m_alu_result),  64'h1111_2222);
    check("term.tmo",    64'(fpu_timeout_o), 64'd0);
    check("term.commit", 64'(m_commit),      64'd1);

    // Timeout with flush pulses ignored during the wait.
    drive_e(1'b1, 32'h0000_0400, 5'd8, 1'b1);
    tick();
    drive_e(1'b0, 32'h0, 5'd0, 1'b0);
    for (int i = 1; i < int'(TMO); i++) begin
      flush_i = (i == 2 || i == 5);
      tick();
      check("tmo.valid", 64'(m_valid),          64'd1);
      check("tmo.stall", 64'(stall_upstream_o), 64'd1);
    end
    flush_i = 1'b0;
    check("tmo.early", 64'(fpu_timeout_o), 64'd0);
    tick();
    check("tmo.drop",   64'(m_valid),          64'd0);
    check("tmo.flag",   64'(fpu_timeout_o),    64'd1);
    check("tmo.stall2", 64'(stall_upstream_o), 64'd0);
    check("tmo.alu",    64'(m_alu_result),     64'h400);
    drive_e(1'b1, 32'h0000_0500, 5'd2, 1'b0);
    tick();
    check("tmo.sticky", 64'(fpu_timeout_o), 64'd1);
    check("tmo.resume", 64'(m_commit),      64'd1);

    // Reset mid-wait, then a late done is ignored.
    drive_e(1'b1, 32'h0000_0600, 5'd12, 1'b1);
    tick();
    drive_e(1'b0, 32'h0, 5'd0, 1'b0);
    tick(); tick();
    check("rst.wait", 64'(stall_upstream_o), 64'd1);
    reset = 1'b1;
    tick();
    check_zero("rstmid");
    reset = 1'b0; stall_i = 1'b1; fpu_done_i = 1'b1; fpu_result_i = 32'hCAFE_F00D;
    tick();
    fpu_done_i = 1'b0; stall_i = 1'b0;
    check("late.alu",   64'(m_alu_result),     64'd0);
    check("late.valid", 64'(m_valid),          64'd0);
    check("late.stall", 64'(stall_upstream_o), 64'd0);

    // E valid without FPU request never enters the wait.
    drive_e(1'b1, 32'h0000_0700, 5'd1, 1'b0);
    tick();
    check("nofpu.stall",  64'(stall_upstream_o), 64'd0);
    check("nofpu.fstart", 64'(m_fpu_start),      64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
